// File: rtl/pwm_hbridge.sv
// Signed-duty PWM driver for the DC-motor H-bridge with shadowed duty and dead time.
// Optional low-side short brake on zero duty: define PWM_BRAKE_EN.
`timescale 1ns/1ps
module pwm_hbridge #(
  parameter int W    = 14,
  parameter int DEAD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] duty,
  input  logic         wrt_duty,
  output logic         CH_A,
  output logic         CH_B,
  output logic         prd_end
);

  localparam int CW = W - 1;
  localparam logic [CW-1:0] MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] LAST = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] DLD  = CW'(DEAD - 1);

`ifdef PWM_BRAKE_EN
  typedef enum logic [1:0] {FWD = 2'd0, REV = 2'd1, BRAKE = 2'd2} mode_t;
`else
  typedef enum logic [1:0] {FWD = 2'd0, REV = 2'd1} mode_t;
`endif
  typedef enum logic {ST_RUN, ST_DEAD} state_t;

  logic [CW-1:0] cnt;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] mag;
  logic [W-1:0]  shadow;
  logic [W-1:0]  active;
  logic [W-1:0]  nxt_act;
  logic [W-1:0]  abs_a;
  logic          last;
  logic          on;
  mode_t         mode;
  mode_t         req_nxt;
  mode_t         req_cur;
  state_t        state;

  function automatic mode_t dir_of(input logic [W-1:0] a);
    return a[W-1] ? REV : FWD;
  endfunction

  assign last    = (cnt == LAST);
  assign nxt_act = wrt_duty ? duty : shadow;
  assign abs_a   = active[W-1] ? (~active + 1'b1) : active;
  assign mag     = (abs_a > {1'b0, MAX}) ? MAX : abs_a[CW-1:0];
  assign on      = (cnt < mag);

  // Requested mode for the upcoming period and for the running one.
  always_comb begin
    req_nxt = mode;
    req_cur = mode;
    if (nxt_act != '0) req_nxt = dir_of(nxt_act);
`ifdef PWM_BRAKE_EN
    else req_nxt = BRAKE;
`endif
    if (active != '0) req_cur = dir_of(active);
`ifdef PWM_BRAKE_EN
    else req_cur = BRAKE;
`endif
  end

  // Period counter, end strobe, shadow and boundary load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      prd_end <= 1'b0;
      shadow  <= '0;
      active  <= '0;
    end else begin
      cnt     <= last ? '0 : cnt + 1'b1;
      prd_end <= last;
      if (wrt_duty) shadow <= duty;
      if (last) active <= nxt_act;
    end
  end

  // Drive/dead-time FSM with registered bridge outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      mode  <= FWD;
      dcnt  <= '0;
      CH_A  <= 1'b0;
      CH_B  <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (last && req_nxt != mode) begin
            state <= ST_DEAD;
            dcnt  <= DLD;
          end
`ifdef PWM_BRAKE_EN
          CH_A <= (on && mode == FWD) || mode == BRAKE;
          CH_B <= (on && mode == REV) || mode == BRAKE;
`else
          CH_A <= on && mode == FWD;
          CH_B <= on && mode == REV;
`endif
        end
        ST_DEAD: begin
          CH_A <= 1'b0;
          CH_B <= 1'b0;
          if (dcnt == '0) begin
            mode  <= req_cur;
            state <= ST_RUN;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/pwm_hbridge.md
Name: pwm_hbridge

Overview:
Parametrised successor to the existing single-width PWM unit that drives the DC-motor H-bridge (CH_A/CH_B).
- Takes a signed duty word from the ALU result bus (dst), selects drive direction from its sign and PWM on-time from its magnitude.
- Shadow-buffers duty updates so they take effect only at period boundaries (glitch-free).
- Inserts a programmable dead time on every direction change.
- Emits a period-end strobe so dig_core can synchronise control-loop updates.

Parameters:
W, 14, duty width in bits (two's complement); counter width is W-1; MAX = 2^(W-1)-1
DEAD, 8, dead-time length in clocks (1..MAX-1)

Ports:
clk  input  1  system clock (800 MHz)
rst_n  input  1  asynchronous active-low reset
duty  input  W  signed duty request (two's complement)
wrt_duty  input  1  one-clock strobe; capture duty into shadow register
CH_A  output  1  forward-drive PWM to H-bridge
CH_B  output  1  reverse-drive PWM to H-bridge
prd_end  output  1  one-clock pulse on the last clock of each PWM period

Behaviour:
- Reset and interface: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n. Asserting rst_n low clears everything immediately, including mid-period.
- Reset values: cnt=0, shadow=0, active=0, mode=FWD, state=RUN, dcnt=0, CH_A=0, CH_B=0, prd_end=0.
- Period counter cnt (W-1 bits):
  - Increments every clock and wraps MAX-1 -> 0.
  - Period = MAX clocks (8191 at W=14).
  - prd_end is registered: high for the one clock where cnt==0 follows cnt==MAX-1, i.e. once per MAX clocks.
- Shadow:
  - wrt_duty=1 loads shadow <= duty. Last write wins; any number of writes per period is legal.
- Update point: on the clock where cnt==MAX-1:
  - active <= wrt_duty ? duty : shadow.
  - A write coincident with the boundary bypasses the shadow and applies to the next period.
- Magnitude: mag = |active|, saturated to MAX. The most negative value -2^(W-1) maps to MAX. Absolute value is computed W-bit; no overflow wrap.
- Direction request: req = REV if active<0; FWD if active>0; unchanged if active==0.
- State machine (evaluated at each update point, i.e. for the period starting at cnt==0):
  - RUN -> DEAD when req != mode. dcnt loads DEAD-1.
  - DEAD: both outputs forced low. dcnt decrements each clock. When dcnt==0: mode <= req, state -> RUN.
  - RUN: on = (cnt < mag). CH_A <= on & mode==FWD; CH_B <= on & mode==REV.
  - Outputs are registered and lag the cnt compare by one clock.
  - Dead time consumes the first DEAD clocks of the period's on-time; the compare window is not shifted.
- Invariants:
  - CH_A and CH_B are never high simultaneously (without PWM_BRAKE_EN).
  - mag==MAX gives a constant-high output; mag==0 gives constant low.
  - A duty write never changes the current period's output.
- Direction reversal requested again during DEAD: ignored until the next update point. The dead-time sequence completes first.

Optional Feature:
PWM_BRAKE_EN
- Defined:
  - active==0 requests mode BRAKE, with CH_A=CH_B=1 (low-side short brake).
  - Entry into and exit from BRAKE follow the same DEAD sequence as a direction change (both low for DEAD clocks).
  - Modes are FWD, REV and BRAKE; any mode change inserts dead time.
- Undefined:
  - Zero duty keeps the current mode with both outputs low.
  - The BRAKE state and its logic are absent.

Test Plan:
1. Reset, write 0 -> CH_A=CH_B=0 for all clocks; prd_end pulses exactly every 8191 clocks, first pulse 8191 clocks after reset release.
2. Write +4096 mid-period -> current period unchanged; from the next period CH_A high for 4096 clocks per period, CH_B=0 throughout.
3. From +4096 write -8192 -> at the boundary both outputs low for 8 clocks, then CH_B high for the remaining 8183 clocks. Subsequent periods: CH_B constant high (saturated), CH_A never high.
4. Write +100 then +200 within one period -> next period CH_A high for exactly 200 clocks.
5. Assert wrt_duty with +50 on the cnt==MAX-1 clock -> the immediately following period shows CH_A high for 50 clocks.
6. Drop rst_n mid on-time -> CH_A/CH_B/prd_end go low without waiting for a clock edge. After release, behaviour matches scenario 1. With PWM_BRAKE_EN, going from +100 to 0 -> 8 clocks both low, then both high.
